// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 Scan Code Set 2 decoder.
//   - ps2_state_e : decoder FSM states (2-bit encoding)
//   - prefix and keyboard status byte constants
//   - is_status() : true for bytes the keyboard sends that are not key codes
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StBreak    = 2'd1,
    StExt      = 2'd2,
    StExtBreak = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;

  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_scancode_lut.sv
// Combinational Set 2 make code -> uppercase ASCII table.
//   scancode : input make code
//   ascii    : mapped character (00 when not mapped)
//   hit      : 1 when scancode has a mapping
module ps2_scancode_lut (
  input  logic [7:0] scancode,
  output logic [7:0] ascii,
  output logic       hit
);

  always_comb begin
    ascii = 8'h00;
    hit   = 1'b1;
    unique case (scancode)
      8'h1C: ascii = 8'h41; // A
      8'h32: ascii = 8'h42; // B
      8'h21: ascii = 8'h43; // C
      8'h23: ascii = 8'h44; // D
      8'h24: ascii = 8'h45; // E
      8'h2B: ascii = 8'h46; // F
      8'h34: ascii = 8'h47; // G
      8'h33: ascii = 8'h48; // H
      8'h43: ascii = 8'h49; // I
      8'h3B: ascii = 8'h4A; // J
      8'h42: ascii = 8'h4B; // K
      8'h4B: ascii = 8'h4C; // L
      8'h3A: ascii = 8'h4D; // M
      8'h31: ascii = 8'h4E; // N
      8'h44: ascii = 8'h4F; // O
      8'h4D: ascii = 8'h50; // P
      8'h15: ascii = 8'h51; // Q
      8'h2D: ascii = 8'h52; // R
      8'h1B: ascii = 8'h53; // S
      8'h2C: ascii = 8'h54; // T
      8'h3C: ascii = 8'h55; // U
      8'h2A: ascii = 8'h56; // V
      8'h1D: ascii = 8'h57; // W
      8'h22: ascii = 8'h58; // X
      8'h35: ascii = 8'h59; // Y
      8'h1A: ascii = 8'h5A; // Z
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31; // 1
      8'h1E: ascii = 8'h32; // 2
      8'h26: ascii = 8'h33; // 3
      8'h25: ascii = 8'h34; // 4
      8'h2E: ascii = 8'h35; // 5
      8'h36: ascii = 8'h36; // 6
      8'h3D: ascii = 8'h37; // 7
      8'h3E: ascii = 8'h38; // 8
      8'h46: ascii = 8'h39; // 9
      8'h29: ascii = 8'h20; // space
      8'h5A: ascii = 8'h0D; // enter
      8'h66: ascii = 8'h08; // backspace
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Scan Code Set 2 decoder: filters break/extended/status bytes, maps make
// codes to ASCII and presents them through a one-entry valid/ready register.
//   clk, rst                 : clock, synchronous active-high reset
//   ps2_received_data/_strb  : byte stream from the PS/2 receiver
//   ascii_data, ascii_valid  : pending character for the consumer
//   ascii_ready              : consumer accept
//   overflow                 : one-cycle pulse when a mapped char is dropped
module ps2_scancode_decoder
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  output logic [7:0] ascii_data,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       overflow
);

  ps2_state_e state_q, state_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;

  logic [7:0] lut_ascii;
  logic       lut_hit;

  ps2_scancode_lut u_lut (
    .scancode (ps2_received_data),
    .ascii    (lut_ascii),
    .hit      (lut_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (ps2_received_data_strb) begin
      unique case (state_q)
        StIdle: begin
          if (ps2_received_data == PS2_BREAK)    state_d = StBreak;
          else if (ps2_received_data == PS2_EXT) state_d = StExt;
          else                                   state_d = StIdle;
        end
        StExt: begin
          if (ps2_received_data == PS2_BREAK) state_d = StExtBreak;
          else                                state_d = StIdle;
        end
        StBreak, StExtBreak: state_d = StIdle;
        default:             state_d = StIdle;
      endcase
    end
  end

  // Holding register and overflow.
  logic lookup_en, reg_free, load, drop;

  always_comb begin
    lookup_en  = ps2_received_data_strb && (state_q == StIdle) &&
                 (ps2_received_data != PS2_BREAK) && (ps2_received_data != PS2_EXT) &&
                 !is_status(ps2_received_data);
    // Free if empty or being drained this cycle, allowing back-to-back loads.
    reg_free   = !valid_q || ascii_ready;
    load       = lookup_en && lut_hit && reg_free;
    drop       = lookup_en && lut_hit && !reg_free;

    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = drop;
    if (load) begin
      data_d  = lut_ascii;
      valid_d = 1'b1;
    end else if (valid_q && ascii_ready) begin
      valid_d = 1'b0;
    end
  end

  assign ascii_data  = data_q;
  assign ascii_valid = valid_q;
  assign overflow    = overflow_q;

endmodule
